// File: rtl/ibexc_trace_pkg.sv
// Shared types and record layout for the retirement trace buffer.
// Defining IBEXC_TRACE_TSTAMP_EN appends a 32-bit mcycle timestamp to each record.
package ibexc_trace_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    POST   = 2'd2,
    FROZEN = 2'd3
  } trace_state_e;

  localparam int unsigned PC_LSB     = 0;
  localparam int unsigned INSN_LSB   = 32;
  localparam int unsigned WDATA_LSB  = 64;
  localparam int unsigned RD_LSB     = 96;
  localparam int unsigned TRAP_BIT   = 101;
  localparam int unsigned WTAG_BIT   = 102;
  localparam int unsigned TSTAMP_LSB = 103;

`ifdef IBEXC_TRACE_TSTAMP_EN
  localparam int unsigned TRACE_REC_W = 135;
`else
  localparam int unsigned TRACE_REC_W = 103;
`endif

endpackage

// File: rtl/ibexc_trace_ram.sv
// Trace record storage: one write port, one asynchronous read port.
// Contents are never reset; the buffer masks them while empty.
module ibexc_trace_ram
  import ibexc_trace_pkg::*;
#(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = TRACE_REC_W
) (
  input  logic                     clk_i,
  input  logic                     we,
  input  logic [$clog2(Depth)-1:0] waddr,
  input  logic [Width-1:0]         wdata,
  input  logic [$clog2(Depth)-1:0] raddr,
  output logic [Width-1:0]         rdata
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ibexc_trace_buffer.sv
// Retirement trace buffer with PC trigger, post-trigger window and FIFO readout.
// Optional timestamp field enabled by defining IBEXC_TRACE_TSTAMP_EN.
module ibexc_trace_buffer
  import ibexc_trace_pkg::*;
#(
  parameter int unsigned Depth    = 16,
  parameter int unsigned PostTrig = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     trace_en_i,
  input  logic                     wrap_mode_i,
  input  logic                     trig_en_i,
  input  logic [31:0]              trig_pc_i,
  input  logic                     clear_i,
  input  logic                     rvfi_valid_i,
  input  logic [31:0]              rvfi_pc_rdata_i,
  input  logic [31:0]              rvfi_insn_i,
  input  logic [31:0]              rvfi_rd_wdata_i,
  input  logic [4:0]               rvfi_rd_addr_i,
  input  logic                     rvfi_trap_i,
  input  logic                     rvfi_rd_wtag_i,
  input  logic [63:0]              rvfi_ext_mcycle_i,
  output logic                     rd_valid_o,
  input  logic                     rd_ready_i,
  output logic [TRACE_REC_W-1:0]   rd_data_o,
  output logic [$clog2(Depth):0]   level_o,
  output logic                     overflow_o,
  output logic                     triggered_o,
  output logic                     frozen_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = (PostTrig == 0) ? 1 : $clog2(PostTrig + 1);

  trace_state_e   state_reg, state_next;
  logic [AW-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [LW-1:0]  level_reg, level_next;
  logic [CW-1:0]  post_cnt_reg, post_cnt_next;
  logic           overflow_reg, overflow_next;
  logic           triggered_reg, triggered_next;

  logic                   we;
  logic [TRACE_REC_W-1:0] rec;
  logic [TRACE_REC_W-1:0] ram_rdata;
  logic                   full;
  logic                   capture;
  logic                   pop;
  logic                   push_ok;
  logic                   adv_rd;
  logic                   trig_hit;

  always_comb begin
    rec = '0;
    rec[PC_LSB +: 32]    = rvfi_pc_rdata_i;
    rec[INSN_LSB +: 32]  = rvfi_insn_i;
    rec[WDATA_LSB +: 32] = rvfi_rd_wdata_i;
    rec[RD_LSB +: 5]     = rvfi_rd_addr_i;
    rec[TRAP_BIT]        = rvfi_trap_i;
    rec[WTAG_BIT]        = rvfi_rd_wtag_i;
`ifdef IBEXC_TRACE_TSTAMP_EN
    rec[TSTAMP_LSB +: 32] = rvfi_ext_mcycle_i[31:0];
`endif
  end

  // Only the low timestamp word is ever recorded.
  logic unused_mcycle;
`ifdef IBEXC_TRACE_TSTAMP_EN
  assign unused_mcycle = ^rvfi_ext_mcycle_i[63:32];
`else
  assign unused_mcycle = ^rvfi_ext_mcycle_i;
`endif

  assign full     = (level_reg == LW'(Depth));
  assign capture  = !clear_i && rvfi_valid_i && trace_en_i &&
                    ((state_reg == ARMED) || (state_reg == POST));
  assign pop      = !clear_i && rd_valid_o && rd_ready_i;
  assign trig_hit = trig_en_i && (rvfi_pc_rdata_i == trig_pc_i);
  // A full buffer accepts a record if space frees this cycle or wrapping is allowed.
  assign push_ok  = capture && (!full || pop || wrap_mode_i);
  assign adv_rd   = pop || (capture && full && wrap_mode_i);
  assign we       = push_ok;

  always_comb begin
    state_next     = state_reg;
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    level_next     = level_reg;
    post_cnt_next  = post_cnt_reg;
    overflow_next  = overflow_reg;
    triggered_next = triggered_reg;

    if (clear_i) begin
      state_next     = IDLE;
      wr_ptr_next    = '0;
      rd_ptr_next    = '0;
      level_next     = '0;
      post_cnt_next  = '0;
      overflow_next  = 1'b0;
      triggered_next = 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_next = wr_ptr_reg + AW'(1);
      end
      if (adv_rd) begin
        rd_ptr_next = rd_ptr_reg + AW'(1);
      end
      if (push_ok && !adv_rd) begin
        level_next = level_reg + LW'(1);
      end else if (adv_rd && !push_ok) begin
        level_next = level_reg - LW'(1);
      end
      if (capture && full && !pop) begin
        overflow_next = 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (trace_en_i) state_next = ARMED;
        end
        ARMED: begin
          if (!trace_en_i) begin
            state_next = IDLE;
          end else if (capture && trig_hit) begin
            triggered_next = 1'b1;
            post_cnt_next  = CW'(PostTrig);
            state_next     = (PostTrig == 0) ? FROZEN : POST;
          end
        end
        POST: begin
          if (!trace_en_i) begin
            state_next = IDLE;
          end else if (capture) begin
            post_cnt_next = post_cnt_reg - CW'(1);
            if (post_cnt_reg == CW'(1)) state_next = FROZEN;
          end
        end
        FROZEN: begin
          if (!trace_en_i) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= IDLE;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      post_cnt_reg  <= '0;
      overflow_reg  <= 1'b0;
      triggered_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      level_reg     <= level_next;
      post_cnt_reg  <= post_cnt_next;
      overflow_reg  <= overflow_next;
      triggered_reg <= triggered_next;
    end
  end

  ibexc_trace_ram #(
    .Depth(Depth),
    .Width(TRACE_REC_W)
  ) u_ram (
    .clk_i (clk_i),
    .we    (we),
    .waddr (wr_ptr_reg),
    .wdata (rec),
    .raddr (rd_ptr_reg),
    .rdata (ram_rdata)
  );

  assign rd_valid_o  = (level_reg != '0);
  // Uninitialised storage stays hidden until something has been written.
  assign rd_data_o   = rd_valid_o ? ram_rdata : '0;
  assign level_o     = level_reg;
  assign overflow_o  = overflow_reg;
  assign triggered_o = triggered_reg;
  assign frozen_o    = (state_reg == FROZEN);

endmodule

// File: tb/tb_ibexc_trace_buffer.sv
// Directed scoreboard bench for ibexc_trace_buffer (Depth=16, PostTrig=3).
module tb_ibexc_trace_buffer;
  import ibexc_trace_pkg::*;

  localparam int unsigned DEPTH = 16;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic                   trace_en_i, wrap_mode_i, trig_en_i, clear_i;
  logic [31:0]            trig_pc_i;
  logic                   rvfi_valid_i;
  logic [31:0]            rvfi_pc_rdata_i, rvfi_insn_i, rvfi_rd_wdata_i;
  logic [4:0]             rvfi_rd_addr_i;
  logic                   rvfi_trap_i, rvfi_rd_wtag_i;
  logic [63:0]            rvfi_ext_mcycle_i;
  logic                   rd_valid_o, rd_ready_i;
  logic [TRACE_REC_W-1:0] rd_data_o;
  logic [4:0]             level_o;
  logic                   overflow_o, triggered_o, frozen_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit model_wrap = 1'b0;
  logic [102:0] exp_q [$];

  always #5 clk_i = ~clk_i;

  ibexc_trace_buffer #(.Depth(DEPTH), .PostTrig(3)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .trace_en_i(trace_en_i), .wrap_mode_i(wrap_mode_i),
    .trig_en_i(trig_en_i), .trig_pc_i(trig_pc_i), .clear_i(clear_i),
    .rvfi_valid_i(rvfi_valid_i), .rvfi_pc_rdata_i(rvfi_pc_rdata_i), .rvfi_insn_i(rvfi_insn_i),
    .rvfi_rd_wdata_i(rvfi_rd_wdata_i), .rvfi_rd_addr_i(rvfi_rd_addr_i), .rvfi_trap_i(rvfi_trap_i),
    .rvfi_rd_wtag_i(rvfi_rd_wtag_i), .rvfi_ext_mcycle_i(rvfi_ext_mcycle_i),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o),
    .level_o(level_o), .overflow_o(overflow_o), .triggered_o(triggered_o), .frozen_o(frozen_o)
  );

  function automatic logic [102:0] mk_rec(input logic [31:0] pc);
    logic [31:0] insn;
    insn = pc ^ 32'hA5A5_5A5A;
    return {pc[3], pc[2], pc[6:2], ~pc, insn, pc};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; the scoreboard follows what the buffer should do.
  task automatic cyc(input bit v, input logic [31:0] pc, input bit rdy, input bit clr,
                     input bit cap_exp);
    logic [102:0] r;
    r = mk_rec(pc);
    rvfi_valid_i    = v;
    rvfi_pc_rdata_i = pc;
    rvfi_insn_i     = r[63:32];
    rvfi_rd_wdata_i = r[95:64];
    rvfi_rd_addr_i  = r[100:96];
    rvfi_trap_i     = r[101];
    rvfi_rd_wtag_i  = r[102];
    rd_ready_i      = rdy;
    clear_i         = clr;
    #1;
    if (clr) begin
      exp_q.delete();
    end else begin
      if (rdy && exp_q.size() > 0) begin
        check("pop_valid", 128'(rd_valid_o), 128'(1'b1));
        check("pop_data", 128'(rd_data_o[102:0]), 128'(exp_q.pop_front()));
      end
      if (v && cap_exp) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(r);
        else if (model_wrap) begin
          void'(exp_q.pop_front());
          exp_q.push_back(r);
        end
      end
    end
    @(posedge clk_i);
    #1;
    rvfi_valid_i = 1'b0;
    rd_ready_i   = 1'b0;
    clear_i      = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check({tag, "_drained_level"}, 128'(level_o), 128'(0));
    check({tag, "_drained_valid"}, 128'(rd_valid_o), 128'(0));
  endtask

  task automatic clear_and_rearm();
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_ni = 1'b0; trace_en_i = 1'b0; wrap_mode_i = 1'b0; trig_en_i = 1'b0;
    trig_pc_i = 32'h0; clear_i = 1'b0; rvfi_valid_i = 1'b0; rvfi_pc_rdata_i = '0;
    rvfi_insn_i = '0; rvfi_rd_wdata_i = '0; rvfi_rd_addr_i = '0; rvfi_trap_i = 1'b0;
    rvfi_rd_wtag_i = 1'b0; rvfi_ext_mcycle_i = 64'h1234_5678_9ABC_DEF0; rd_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_level", 128'(level_o), 128'(0));
    check("rst_valid", 128'(rd_valid_o), 128'(0));
    check("rst_data", 128'(rd_data_o), 128'(0));
    check("rst_flags", 128'({overflow_o, triggered_o, frozen_o}), 128'(0));
    rst_ni = 1'b1;

    // Drop mode: 20 retirements into 16 entries, oldest 16 kept.
    trace_en_i = 1'b1; wrap_mode_i = 1'b0; model_wrap = 1'b0;
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 32'h1000 + 32'(4 * i), 1'b0, 1'b0, 1'b1);
    check("drop_level", 128'(level_o), 128'(16));
    check("drop_overflow", 128'(overflow_o), 128'(1));
    drain("drop");
    clear_and_rearm();
    check("clear_overflow", 128'(overflow_o), 128'(0));

    // Wrap mode: 20 retirements, newest 16 kept.
    wrap_mode_i = 1'b1; model_wrap = 1'b1;
    for (int i = 0; i < 20; i++) cyc(1'b1, 32'h2000 + 32'(4 * i), 1'b0, 1'b0, 1'b1);
    check("wrap_level", 128'(level_o), 128'(16));
    check("wrap_overflow", 128'(overflow_o), 128'(1));
    check("wrap_head_pc", 128'(rd_data_o[31:0]), 128'(32'h2010));
    drain("wrap");

    // Full with simultaneous capture and pop.
    clear_and_rearm();
    wrap_mode_i = 1'b0; model_wrap = 1'b0;
    for (int i = 0; i < 16; i++) cyc(1'b1, 32'h3000 + 32'(4 * i), 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h3100, 1'b1, 1'b0, 1'b1);
    check("fullpop_level", 128'(level_o), 128'(16));
    check("fullpop_overflow", 128'(overflow_o), 128'(0));
    drain("fullpop");

    // Clear beats capture and pop; the FSM spends a cycle in IDLE afterwards.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h4000 + 32'(4 * i), 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h4100, 1'b1, 1'b1, 1'b0);
    check("clr_level", 128'(level_o), 128'(0));
    check("clr_flags", 128'({rd_valid_o, overflow_o, triggered_o, frozen_o}), 128'(0));
    cyc(1'b1, 32'h4104, 1'b0, 1'b0, 1'b0);
    check("clr_idle_nocap", 128'(level_o), 128'(0));

    // Trigger at 0x80 with a three-record post window.
    trig_en_i = 1'b1; trig_pc_i = 32'h80;
    cyc(1'b1, 32'h7C, 1'b0, 1'b0, 1'b1);
    check("pre_trig", 128'(triggered_o), 128'(0));
    cyc(1'b1, 32'h80, 1'b0, 1'b0, 1'b1);
    check("trig_hit", 128'({triggered_o, frozen_o}), 128'(2'b10));
    cyc(1'b1, 32'h84, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h88, 1'b0, 1'b0, 1'b1);
    check("post_not_frozen", 128'(frozen_o), 128'(0));
    cyc(1'b1, 32'h8C, 1'b0, 1'b0, 1'b1);
    check("frozen", 128'(frozen_o), 128'(1));
    cyc(1'b1, 32'h90, 1'b0, 1'b0, 1'b0);
    check("frozen_level", 128'(level_o), 128'(5));
    drain("trig");

    // Reset in the middle of the post window.
    clear_and_rearm();
    cyc(1'b1, 32'h80, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h84, 1'b0, 1'b0, 1'b1);
    rst_ni = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_level", 128'(level_o), 128'(0));
    check("midrst_data", 128'(rd_data_o), 128'(0));
    check("midrst_flags", 128'({rd_valid_o, overflow_o, triggered_o, frozen_o}), 128'(0));
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    trig_en_i = 1'b0;
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h5000 + 32'(4 * i), 1'b0, 1'b0, 1'b1);
    check("rearm_level", 128'(level_o), 128'(3));
    check("rearm_trig", 128'(triggered_o), 128'(0));
    drain("rearm");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ibexc_trace_buffer.md
IBEXC_TRACE_BUFFER -- requirements
Module: ibexc_trace_buffer

Interface
REQ-001 SHALL have parameter Depth, default 16, meaning the number of record entries; it is a power of two and at least 2.
REQ-002 SHALL have parameter PostTrig, default 8, meaning the number of records captured after the trigger record.
REQ-003 clk_i  in  1  core clock.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 trace_en_i  in  1  capture enable.
REQ-006 wrap_mode_i  in  1  1 = overwrite oldest record when full; 0 = drop new record when full.
REQ-007 trig_en_i  in  1  enables PC trigger.
REQ-008 trig_pc_i  in  32  trigger PC.
REQ-009 clear_i  in  1  synchronous clear pulse.
REQ-010 rvfi_valid_i  in  1  retirement strobe.
REQ-011 rvfi_pc_rdata_i, rvfi_insn_i, rvfi_rd_wdata_i  in  32 each  retired PC, instruction and rd write data.
REQ-012 rvfi_rd_addr_i  in  5  rd index.
REQ-013 rvfi_trap_i  in  1  trap flag.
REQ-014 rvfi_rd_wtag_i  in  1  rd capability tag.
REQ-015 rvfi_ext_mcycle_i  in  64  cycle counter.
REQ-016 rd_valid_o  out  1  buffer non-empty.
REQ-017 rd_ready_i  in  1  consumer pop.
REQ-018 rd_data_o  out  TRACE_REC_W  oldest record.
REQ-019 level_o  out  $clog2(Depth)+1  occupancy.
REQ-020 overflow_o  out  1  sticky loss or overwrite flag.
REQ-021 triggered_o  out  1  sticky trigger-hit flag.
REQ-022 frozen_o  out  1  state == FROZEN.

Function
REQ-023 FSM states SHALL be IDLE, ARMED, POST and FROZEN.
REQ-024 Transitions: IDLE->ARMED when trace_en_i=1; ARMED/POST->IDLE when trace_en_i=0; FROZEN->IDLE when trace_en_i=0; buffer contents SHALL be retained on every transition.
REQ-025 A capture SHALL occur in the cycle rvfi_valid_i=1 while state is ARMED or POST and trace_en_i=1; it writes the record at the write pointer at the clock edge.
REQ-026 Trigger: in ARMED, when a capture has trig_en_i=1 and rvfi_pc_rdata_i==trig_pc_i, the record SHALL be captured, triggered_o set, and the post counter loaded with PostTrig; the next state is POST, or FROZEN if PostTrig=0.
REQ-027 In POST each capture SHALL decrement the post counter; the capture that makes it 0 is stored and the state moves to FROZEN. FROZEN captures nothing.
REQ-028 Readout: rd_valid_o=(level_o!=0); rd_data_o SHALL be the entry at the read pointer combinationally; a pop occurs on rd_valid_o&&rd_ready_i, in any state.
REQ-029 Full with a simultaneous pop: capture and pop SHALL both proceed, level unchanged, no overflow.
REQ-030 Full with no pop and wrap_mode_i=0: the record SHALL be dropped, pointers unchanged, overflow_o set.
REQ-031 Full with no pop and wrap_mode_i=1: the oldest entry SHALL be overwritten, both pointers advance, level stays Depth, overflow_o set.
REQ-032 Pointers SHALL wrap modulo Depth; empty and full are distinguished by level, not by pointer equality.
REQ-033 clear_i SHALL take priority over capture and pop: level to 0, pointers to 0, overflow_o and triggered_o cleared, state to IDLE next cycle.
REQ-034 Record packing, LSB first: pc[31:0], insn[63:32], wdata[95:64], rd[100:96], trap[101], wtag[102]; TRACE_REC_W=103.

Reset
REQ-035 Reset SHALL set state IDLE, pointers/level 0, post counter 0, and all flags 0, so every output is 0 including rd_data_o; memory contents are not reset and are unobservable while empty.
REQ-036 Reset asserted mid-capture or mid-POST SHALL abandon the operation with no partial state surviving.

Configuration
REQ-037 With IBEXC_TRACE_TSTAMP_EN defined, each record SHALL append rvfi_ext_mcycle_i[31:0] at [134:103], making TRACE_REC_W=135.
REQ-038 Without IBEXC_TRACE_TSTAMP_EN, TRACE_REC_W=103, rvfi_ext_mcycle_i SHALL be unused, and behaviour is otherwise identical.

Structure
REQ-039 The trace_state_e enum, field offsets and TRACE_REC_W SHALL live in a shared package ibexc_trace_pkg, with TRACE_REC_W conditioned on the macro.
REQ-040 Storage SHALL be one sub-module, ibexc_trace_ram (1W1R, async read, Depth x TRACE_REC_W).

Verification
REQ-041 Depth=16, wrap=0: 20 retirements in ARMED, no pop -> level=16, overflow=1, pops return PCs of retirements 1-16 in order.
REQ-042 Depth=16, wrap=1: 20 retirements -> level=16, overflow=1, first pop returns the 5th record's PC.
REQ-043 PostTrig=3, trig_pc=0x0000_0080: PCs 0x7C,0x80,0x84,0x88,0x8C,0x90 -> records 0x7C-0x8C stored (5), frozen_o=1, 0x90 absent.
REQ-044 Full buffer with rvfi_valid_i=1 and rd_ready_i=1 in the same cycle -> level stays 16, overflow_o=0.
REQ-045 clear_i with rvfi_valid_i=1 and rd_ready_i=1 in the same cycle -> level=0, flags=0, state IDLE, no record stored.
REQ-046 rst_ni low mid-POST -> all outputs 0; after reset with trace_en_i=1 the FSM re-arms and captures from level 0.
